// File: rtl/biquad_coeff_sequencer.sv
// Biquad coefficient sequencer: host-written buffer shifted into the filter, highest address first, then committed.
// Optional readback port pair (rd_adr_i / rd_dat_o) enabled by defining BIQUAD_COEFF_READBACK_EN.
//
// state  | meaning
// IDLE   | host may write the buffer; load_i starts a sequence
// SHIFT  | one coefficient per cycle on coeff_dat_o with coeff_wr_o high
// SETTLE | SETTLE_CYCLES quiet cycles before the commit
// UPDATE | coeff_update_o high for one cycle
module biquad_coeff_sequencer #(
    parameter int NCOEFF        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int ADRBITS       = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADRBITS-1:0] wr_adr_i,
    input  logic [17:0]        wr_dat_i,
    input  logic               wr_i,
    input  logic               load_i,
`ifdef BIQUAD_COEFF_READBACK_EN
    input  logic [ADRBITS-1:0] rd_adr_i,
    output logic [17:0]        rd_dat_o,
`endif
    output logic [17:0]        coeff_dat_o,
    output logic               coeff_wr_o,
    output logic               coeff_update_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               wr_err_o
);

    localparam int              IDXW      = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NCOEFF - 1);
    localparam logic [ADRBITS:0] NCOEFF_A = (ADRBITS + 1)'(NCOEFF);
    localparam logic [3:0]      SETTLE_LD = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, UPDATE} state_t;

    state_t          state, state_nx;
    logic [17:0]     coeff_buf [NCOEFF];
    logic [IDXW-1:0] idx, idx_nx;
    logic [3:0]      settle_cnt, settle_nx;
    logic            wr_nx, upd_nx;
    logic            wr_ok, wr_drop;

    assign wr_ok   = wr_i && (state == IDLE) && !load_i && ({1'b0, wr_adr_i} < NCOEFF_A);
    assign wr_drop = wr_i && !wr_ok;

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        settle_nx = settle_cnt;
        wr_nx     = 1'b0;
        upd_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (load_i) begin
                    state_nx = SHIFT;
                    idx_nx   = LAST_IDX;
                    wr_nx    = 1'b1;
                end
            end
            SHIFT: begin
                if (idx != '0) begin
                    idx_nx = idx - 1'b1;
                    wr_nx  = 1'b1;
                end else if (SETTLE_CYCLES == 0) begin
                    state_nx = UPDATE;
                    upd_nx   = 1'b1;
                end else begin
                    state_nx  = SETTLE;
                    settle_nx = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nx = UPDATE;
                    upd_nx   = 1'b1;
                end else begin
                    settle_nx = settle_cnt - 1'b1;
                end
            end
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            wr_err_o       <= 1'b0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            settle_cnt     <= settle_nx;
            coeff_wr_o     <= wr_nx;
            coeff_dat_o    <= wr_nx ? coeff_buf[idx_nx] : '0;
            coeff_update_o <= upd_nx;
            busy_o         <= (state_nx != IDLE);
            done_o         <= (state == UPDATE);
            wr_err_o       <= wr_drop;
        end
    end

    // Buffer contents survive reset; only the write path is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            coeff_buf[wr_adr_i[IDXW-1:0]] <= wr_dat_i;
    end

`ifdef BIQUAD_COEFF_READBACK_EN
    always_ff @(posedge clk) begin
        if ({1'b0, rd_adr_i} < NCOEFF_A)
            rd_dat_o <= coeff_buf[rd_adr_i[IDXW-1:0]];
        else
            rd_dat_o <= '0;
    end
`endif

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Directed bench: dut_a uses SETTLE_CYCLES=2, dut_b uses SETTLE_CYCLES=0; both share stimulus.
module tb_biquad_coeff_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  wr_adr_i;
    logic [17:0] wr_dat_i;
    logic        wr_i;
    logic        load_i;
    logic [17:0] a_dat, b_dat;
    logic        a_wr, a_upd, a_busy, a_done, a_err;
    logic        b_wr, b_upd, b_busy, b_done, b_err;
`ifdef BIQUAD_COEFF_READBACK_EN
    logic [5:0]  rd_adr_i;
    logic [17:0] a_rd, b_rd;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    biquad_coeff_sequencer #(.NCOEFF(8), .SETTLE_CYCLES(2), .ADRBITS(6)) dut_a (
        .clk(clk), .rst(rst), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i), .wr_i(wr_i), .load_i(load_i),
`ifdef BIQUAD_COEFF_READBACK_EN
        .rd_adr_i(rd_adr_i), .rd_dat_o(a_rd),
`endif
        .coeff_dat_o(a_dat), .coeff_wr_o(a_wr), .coeff_update_o(a_upd),
        .busy_o(a_busy), .done_o(a_done), .wr_err_o(a_err)
    );

    biquad_coeff_sequencer #(.NCOEFF(8), .SETTLE_CYCLES(0), .ADRBITS(6)) dut_b (
        .clk(clk), .rst(rst), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i), .wr_i(wr_i), .load_i(load_i),
`ifdef BIQUAD_COEFF_READBACK_EN
        .rd_adr_i(rd_adr_i), .rd_dat_o(b_rd),
`endif
        .coeff_dat_o(b_dat), .coeff_wr_o(b_wr), .coeff_update_o(b_upd),
        .busy_o(b_busy), .done_o(b_done), .wr_err_o(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [5:0] adr, input logic [17:0] dat);
        wr_adr_i = adr;
        wr_dat_i = dat;
        wr_i     = 1'b1;
        step();
        wr_i     = 1'b0;
    endtask

    // Load at cycle T and check both DUTs through T+13; buffer expected to hold 0x100+i.
    task automatic run_load(input string tag, input bit with_wr);
        load_i = 1'b1;
        if (with_wr) begin
            wr_adr_i = 6'd0;
            wr_dat_i = 18'h3FFFF;
            wr_i     = 1'b1;
        end
        step();
        load_i = 1'b0;
        wr_i   = 1'b0;
        check({tag, " err_t1"}, 32'(a_err), 32'(with_wr));
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s a_wr k%0d", tag, k), 32'(a_wr), 32'd1);
            check($sformatf("%s a_dat k%0d", tag, k), 32'(a_dat), 32'h107 - 32'(k));
            check($sformatf("%s b_dat k%0d", tag, k), 32'(b_dat), 32'h107 - 32'(k));
            check($sformatf("%s a_busy k%0d", tag, k), 32'(a_busy), 32'd1);
            step();
        end
        check({tag, " t9 b_upd"}, 32'(b_upd), 32'd1);
        check({tag, " t9 a_wr"}, {a_wr, 13'd0, a_dat}, 32'd0);
        check({tag, " t9 a_upd"}, 32'(a_upd), 32'd0);
        step();
        check({tag, " t10 b_done"}, 32'(b_done), 32'd1);
        check({tag, " t10 a_busy_upd"}, {a_busy, a_upd}, 32'b10);
        step();
        check({tag, " t11 a_upd_busy"}, {a_upd, a_busy, a_done}, 32'b110);
        step();
        check({tag, " t12 a_done"}, {a_upd, a_busy, a_done}, 32'b001);
        step();
        check({tag, " t13 a_done_low"}, 32'(a_done), 32'd0);
    endtask

    initial begin
        int seen;
        int a_up [2];
        int b_up [2];
        int na, nb;

        rst = 1'b1; wr_i = 1'b0; load_i = 1'b0; wr_adr_i = '0; wr_dat_i = '0;
`ifdef BIQUAD_COEFF_READBACK_EN
        rd_adr_i = '0;
`endif
        repeat (3) step();
        check("reset a_outs", {a_wr, a_upd, a_busy, a_done, a_err, 9'd0, a_dat}, 32'd0);
        check("reset b_outs", {b_wr, b_upd, b_busy, b_done, b_err, 9'd0, b_dat}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) host_write(6'(i), 18'h100 + 18'(i));
        check("write ok no err", 32'(a_err), 32'd0);

        host_write(6'd8, 18'h3FFFF);
        check("oob write err", {a_err, b_err}, 32'b11);
        step();
        check("oob err one pulse", 32'(a_err), 32'd0);

        run_load("seq1", 1'b0);

        // Write attempted during busy must be dropped.
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        host_write(6'd3, 18'h3FFFF);
        check("busy write err", 32'(a_err), 32'd1);
        repeat (15) step();
        run_load("seq2", 1'b0);

        // Simultaneous write and load in IDLE: write dropped, load proceeds.
        run_load("seq3", 1'b1);

        // Reset at T+5 aborts the sequence.
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort a_outs", {a_wr, a_upd, a_busy, a_done, a_err, 9'd0, a_dat}, 32'd0);
        check("abort b_outs", {b_wr, b_upd, b_busy, b_done, b_err, 9'd0, b_dat}, 32'd0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (a_upd || a_done || b_upd || b_done || a_busy) seen++;
        end
        check("abort no upd/done", 32'(seen), 32'd0);
        run_load("seq4", 1'b0);

        // load_i held high for 30 cycles.
        na = 0; nb = 0;
        a_up[0] = -1; a_up[1] = -1; b_up[0] = -1; b_up[1] = -1;
        load_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (a_upd && na < 2) begin a_up[na] = c; na++; end
            if (b_upd && nb < 2) begin b_up[nb] = c; nb++; end
        end
        load_i = 1'b0;
        check("held a_upd1", 32'(a_up[0]), 32'd11);
        check("held a_upd2", 32'(a_up[1]), 32'd23);
        check("held b_upd1", 32'(b_up[0]), 32'd9);
        check("held b_upd2", 32'(b_up[1]), 32'd19);
        repeat (15) step();
        check("held idle", {a_busy, b_busy}, 32'd0);

`ifdef BIQUAD_COEFF_READBACK_EN
        rd_adr_i = 6'd5;
        step();
        check("rd adr5", 32'(a_rd), 32'h105);
        rd_adr_i = 6'd9;
        step();
        check("rd adr9", 32'(a_rd), 32'd0);
        rd_adr_i = 6'd0;
        step();
        check("rd adr0", 32'(a_rd), 32'h100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_sequencer.md
BIQUAD_COEFF_SEQUENCER -- requirements
Module: biquad_coeff_sequencer

Interface
REQ-001 SHALL have parameter NCOEFF, default 8: number of 18-bit coefficients shifted per load (2..64).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles between the last shifted word and the update pulse (0..15).
REQ-003 SHALL have parameter ADRBITS, default 6: host address width, with 2**ADRBITS >= NCOEFF.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wr_adr_i, input, ADRBITS: host coefficient buffer address.
REQ-007 SHALL have port wr_dat_i, input, 18: host coefficient data.
REQ-008 SHALL have port wr_i, input, 1: host buffer write strobe.
REQ-009 SHALL have port load_i, input, 1: request to shift the buffer into the filter and commit it.
REQ-010 SHALL have port coeff_dat_o, output, 18: to the filter coefficient data input.
REQ-011 SHALL have port coeff_wr_o, output, 1: to the filter coefficient write (B1 clock-enable) input.
REQ-012 SHALL have port coeff_update_o, output, 1: to the filter coefficient update (B2 clock-enable) input.
REQ-013 SHALL have port busy_o, output, 1: high while a load sequence is in progress.
REQ-014 SHALL have port done_o, output, 1: one-cycle pulse when a sequence completes.
REQ-015 SHALL have port wr_err_o, output, 1: one-cycle pulse when a host write is dropped.

Function
REQ-016 SHALL hold an NCOEFF x 18 buffer; when IDLE, wr_i=1, load_i=0 and wr_adr_i<NCOEFF, it SHALL write wr_dat_i at wr_adr_i.
REQ-017 SHALL have FSM states IDLE, SHIFT, SETTLE, UPDATE; reset state is IDLE.
REQ-018 IDLE->SHIFT when load_i=1 (cycle T); load_i SHALL be ignored in all other states, with no queuing.
REQ-019 In SHIFT, for k=0..NCOEFF-1, at cycle T+1+k it SHALL drive coeff_wr_o=1 and coeff_dat_o=buffer[NCOEFF-1-k] (highest address first).
REQ-020 SHIFT->SETTLE after word k=NCOEFF-1; SETTLE SHALL last exactly SETTLE_CYCLES cycles and is skipped when SETTLE_CYCLES=0.
REQ-021 In UPDATE (cycle T+1+NCOEFF+SETTLE_CYCLES) it SHALL drive coeff_update_o=1 for exactly one cycle, then go to IDLE.
REQ-022 done_o SHALL pulse in the cycle after UPDATE.
REQ-023 busy_o SHALL be high from T+1 through the UPDATE cycle inclusive.
REQ-024 coeff_dat_o SHALL be 0 whenever coeff_wr_o=0.
REQ-025 All outputs SHALL be registered.
REQ-026 A write SHALL be dropped, with wr_err_o pulsing the next cycle, when: busy_o=1; wr_i and load_i are both high in IDLE; or wr_adr_i>=NCOEFF.
REQ-027 load_i held high continuously SHALL start a new sequence on each IDLE cycle; successive coeff_update_o pulses are therefore NCOEFF+SETTLE_CYCLES+2 cycles apart.

Reset
REQ-028 rst SHALL force IDLE and drive coeff_dat_o=0, coeff_wr_o=0, coeff_update_o=0, busy_o=0, done_o=0 and wr_err_o=0 on the next edge, including mid-sequence.
REQ-029 A sequence aborted by reset SHALL NOT produce coeff_update_o or done_o.
REQ-030 Buffer contents SHALL be unaffected by rst.

Configuration
REQ-031 With macro BIQUAD_COEFF_READBACK_EN defined, the block SHALL add ports rd_adr_i (input, ADRBITS) and rd_dat_o (output, 18): rd_dat_o = buffer[rd_adr_i], one-cycle registered latency, 0 for out-of-range addresses.
REQ-032 Without BIQUAD_COEFF_READBACK_EN, those ports and their logic SHALL be absent.

Verification
REQ-033 NCOEFF=8, SETTLE=2; write buffer[i]=0x100+i; load at T -> coeff_wr_o high T+1..T+8 with data 0x107..0x100; coeff_update_o at T+11; done_o at T+12.
REQ-034 Write adr 3 = 0x3FFFF during busy -> wr_err_o pulses; a subsequent load still shifts the old buffer[3]=0x103.
REQ-035 Assert rst at T+5 of a sequence -> all outputs 0 at T+6; no update or done pulse; a next load shifts the full 0x107..0x100.
REQ-036 SETTLE_CYCLES=0 -> coeff_update_o at T+9, directly after the last word (0x100) at T+8.
REQ-037 load_i held high for 30 cycles with NCOEFF=8, SETTLE=2 -> update pulses at T+11 and T+23.
REQ-038 With BIQUAD_COEFF_READBACK_EN: rd_adr_i=5 -> rd_dat_o=0x105 one cycle later; rd_adr_i=9 -> rd_dat_o=0.
